// File: rtl/seq_mult_pkg.sv
// Shared definitions for the shift-add sequential multiplier:
// FSM state encodings and the iteration counter width helper.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // The counter must be able to hold WIDTH itself, hence w+1.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_mult_param_dp.sv
// Datapath for seq_mult_param: operand magnitudes, shift-add accumulation,
// final negation and the status flags the controlling FSM needs.
module seq_mult_param_dp
    import seq_mult_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SIGNED_EN = 1
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic                 add_i,
    input  logic                 fix_i,
    input  logic                 signed_mode_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 zero_o,
    output logic                 lsb_b_o,
    output logic                 cnt_max_o,
    output logic                 neg_o,
    output logic [2*WIDTH-1:0]   prod_o,
    output logic [2*WIDTH-1:0]   prod_neg_o
);

    localparam int CW = cnt_width(WIDTH);

    logic [2*WIDTH-1:0] aReg_q, aReg_d;
    logic [WIDTH-1:0]   bReg_q, bReg_d;
    logic [2*WIDTH-1:0] pReg_q, pReg_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d;

    logic               signedOp;
    logic [WIDTH-1:0]   aAbs;
    logic [WIDTH-1:0]   bAbs;

    // The most negative operand negates to itself, which read unsigned is its magnitude.
    assign signedOp = signed_mode_i && (SIGNED_EN != 0);
    assign aAbs     = (signedOp && a_i[WIDTH-1]) ? -a_i : a_i;
    assign bAbs     = (signedOp && b_i[WIDTH-1]) ? -b_i : b_i;

    always_comb begin
        aReg_d = aReg_q;
        bReg_d = bReg_q;
        pReg_d = pReg_q;
        cnt_d  = cnt_q;
        neg_d  = neg_q;
        if (load_i) begin
            aReg_d = {{WIDTH{1'b0}}, aAbs};
            bReg_d = bAbs;
            pReg_d = '0;
            cnt_d  = '0;
            neg_d  = signedOp && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
        end else if (step_i) begin
            if (add_i) begin
                pReg_d = pReg_q + aReg_q;
            end
            aReg_d = aReg_q << 1;
            bReg_d = bReg_q >> 1;
            cnt_d  = cnt_q + CW'(1);
        end else if (fix_i) begin
            pReg_d = -pReg_q;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            aReg_q <= '0;
            bReg_q <= '0;
            pReg_q <= '0;
            cnt_q  <= '0;
            neg_q  <= 1'b0;
        end else begin
            aReg_q <= aReg_d;
            bReg_q <= bReg_d;
            pReg_q <= pReg_d;
            cnt_q  <= cnt_d;
            neg_q  <= neg_d;
        end
    end

    assign zero_o     = (bReg_q == '0);
    assign lsb_b_o    = bReg_q[0];
    assign cnt_max_o  = (cnt_q == CW'(WIDTH));
    assign neg_o      = neg_q;
    assign prod_o     = pReg_q;
    assign prod_neg_o = -pReg_q;

endmodule

// File: rtl/seq_mult_param.sv
// Parametrised shift-add sequential multiplier with optional signed mode,
// busy/done handshake and early exit once the remaining multiplier bits are zero.
module seq_mult_param
    import seq_mult_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SIGNED_EN = 1
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 go,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    state_e             state_q;
    logic               busy_q;
    logic               done_q;
    logic [2*WIDTH-1:0] p_q;

    logic               zeroB;
    logic               lsbB;
    logic               cntMax;
    logic               negRes;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prodNeg;
    logic               calcEnd;
    logic               loadEn;
    logic               stepEn;
    logic               fixEn;

    assign calcEnd = zeroB || cntMax;
    assign loadEn  = (state_q == ST_IDLE) && go;
    assign stepEn  = (state_q == ST_CALC) && !calcEnd;
    assign fixEn   = (state_q == ST_FIX);

    seq_mult_param_dp #(
        .WIDTH     (WIDTH),
        .SIGNED_EN (SIGNED_EN)
    ) u_dp (
        .clk           (clk),
        .clr           (clr),
        .load_i        (loadEn),
        .step_i        (stepEn),
        .add_i         (stepEn && lsbB),
        .fix_i         (fixEn),
        .signed_mode_i (signed_mode),
        .a_i           (a),
        .b_i           (b),
        .zero_o        (zeroB),
        .lsb_b_o       (lsbB),
        .cnt_max_o     (cntMax),
        .neg_o         (negRes),
        .prod_o        (prod),
        .prod_neg_o    (prodNeg)
    );

    // The product register is loaded on the edge that enters DONE; coming from FIX
    // the datapath is negating on that same edge, so its negated view is captured.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            p_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (go) begin
                        state_q <= ST_CALC;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CALC: begin
                    if (calcEnd) begin
                        if (negRes) begin
                            state_q <= ST_FIX;
                        end else begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            p_q     <= prod;
                        end
                    end
                end
                ST_FIX: begin
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    p_q     <= prodNeg;
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = p_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Self-checking bench for seq_mult_param: three instances (W=4 signed-capable,
// W=8 signed-capable, W=8 unsigned-only) checked against a reference model via a scoreboard.
module tb_seq_mult_param;

    logic        clk = 1'b0;
    logic        clr;
    logic [1:0]  selR;
    logic        go;
    logic        smIn;
    logic [7:0]  aIn;
    logic [7:0]  bIn;

    logic        busy4, done4, busy8, done8, busy8u, done8u;
    logic [7:0]  p4;
    logic [15:0] p8, p8u;
    logic [15:0] pSel;
    logic        busySel, doneSel;

    typedef struct {
        logic [15:0] p;
        int          lat;
        int          busyCyc;
    } exp_t;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    seq_mult_param #(.WIDTH(4), .SIGNED_EN(1)) u_dut4 (
        .clk(clk), .clr(clr), .go(go && selR == 2'd0), .signed_mode(smIn),
        .a(aIn[3:0]), .b(bIn[3:0]), .busy(busy4), .done(done4), .p(p4)
    );

    seq_mult_param #(.WIDTH(8), .SIGNED_EN(1)) u_dut8 (
        .clk(clk), .clr(clr), .go(go && selR == 2'd1), .signed_mode(smIn),
        .a(aIn), .b(bIn), .busy(busy8), .done(done8), .p(p8)
    );

    seq_mult_param #(.WIDTH(8), .SIGNED_EN(0)) u_dut8u (
        .clk(clk), .clr(clr), .go(go && selR == 2'd2), .signed_mode(smIn),
        .a(aIn), .b(bIn), .busy(busy8u), .done(done8u), .p(p8u)
    );

    assign pSel    = (selR == 2'd0) ? {8'h00, p4} : (selR == 2'd1) ? p8 : p8u;
    assign busySel = (selR == 2'd0) ? busy4 : (selR == 2'd1) ? busy8 : busy8u;
    assign doneSel = (selR == 2'd0) ? done4 : (selR == 2'd1) ? done8 : done8u;

    // Reference: exact product, magnitude bit length of b, and whether FIX is visited.
    function automatic exp_t model(input logic [1:0] sel, input bit sm,
                                   input logic [7:0] a, input logic [7:0] b);
        exp_t        e;
        int          w, sa, sb, absb, bl;
        bit          sgn, negF;
        logic [31:0] prod;
        w   = (sel == 2'd0) ? 4 : 8;
        sgn = sm && (sel != 2'd2);
        sa  = (w == 4) ? int'(a[3:0]) : int'(a);
        sb  = (w == 4) ? int'(b[3:0]) : int'(b);
        if (sgn && a[w-1]) sa -= (1 << w);
        if (sgn && b[w-1]) sb -= (1 << w);
        prod = sa * sb;
        e.p  = (w == 4) ? {8'h00, prod[7:0]} : prod[15:0];
        absb = (sb < 0) ? -sb : sb;
        bl   = 0;
        for (int i = 0; i <= 8; i++) if ((absb >> i) != 0) bl = i + 1;
        negF      = sgn && (a[w-1] ^ b[w-1]);
        e.busyCyc = bl + 1 + int'(negF);
        e.lat     = e.busyCyc + 1;
        return e;
    endfunction

    task automatic applyStimulus(input logic [1:0] sel, input bit sm,
                                 input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        selR = sel; smIn = sm; aIn = a; bIn = b; go = 1'b1;
        sbq.push_back(model(sel, sm, a, b));
        @(negedge clk);
        go = 1'b0;
    endtask

    // Observes the selected instance from the current negedge (count 1) until done.
    task automatic waitDone(output int lat, output int busyCyc, output bit ok);
        lat = 0; busyCyc = 0; ok = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (i > 1) @(negedge clk);
            if (busySel) busyCyc++;
            if (doneSel) begin
                lat = i; ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        clr = 1'b0; go = 1'b0; smIn = 1'b0; aIn = '0; bIn = '0; selR = 2'd0;
        #12;
        vectors++;
        if ({busy4, done4, p4} !== 10'd0) begin
            miscompares++; $display("[TB] FAIL reset_w4: got %h expected 0", {busy4, done4, p4});
        end
        vectors++;
        if ({busy8, done8, p8} !== 18'd0) begin
            miscompares++; $display("[TB] FAIL reset_w8: got %h expected 0", {busy8, done8, p8});
        end
        vectors++;
        if ({busy8u, done8u, p8u} !== 18'd0) begin
            miscompares++; $display("[TB] FAIL reset_w8u: got %h expected 0", {busy8u, done8u, p8u});
        end
        @(negedge clk);
        clr = 1'b1;
    endtask

    task automatic test_unsigned_w4();
        exp_t e; int lat, bc; bit ok;
        applyStimulus(2'd0, 1'b0, 8'd13, 8'd11);
        waitDone(lat, bc, ok);
        e = sbq.pop_front();
        vectors++;
        if (!ok || pSel !== e.p || e.p !== 16'h008F) begin
            miscompares++; $display("[TB] FAIL unsigned_w4 p: got %h expected %h ok=%0d", pSel, e.p, ok);
        end
        vectors++;
        if (lat !== e.lat || bc !== 5) begin
            miscompares++; $display("[TB] FAIL unsigned_w4 timing: lat %0d busy %0d expected %0d/5", lat, bc, e.lat);
        end
        @(negedge clk);
        vectors++;
        if (done4 !== 1'b0 || p4 !== 8'h8F) begin
            miscompares++; $display("[TB] FAIL done_pulse: done %b p %h expected 0/8f", done4, p4);
        end
    endtask

    task automatic test_signed_w4();
        exp_t e; int lat, bc; bit ok;
        applyStimulus(2'd0, 1'b1, 8'h08, 8'h07);
        waitDone(lat, bc, ok);
        e = sbq.pop_front();
        vectors++;
        if (!ok || pSel !== 16'h00C8) begin
            miscompares++; $display("[TB] FAIL signed_neg p: got %h expected 00c8", pSel);
        end
        vectors++;
        if (lat !== e.lat || bc !== e.busyCyc) begin
            miscompares++; $display("[TB] FAIL signed_neg timing: lat %0d busy %0d expected %0d/%0d", lat, bc, e.lat, e.busyCyc);
        end
        applyStimulus(2'd0, 1'b1, 8'h08, 8'h08);
        waitDone(lat, bc, ok);
        e = sbq.pop_front();
        vectors++;
        if (!ok || pSel !== 16'h0040 || lat !== e.lat || bc !== 5) begin
            miscompares++; $display("[TB] FAIL signed_minmin: p %h lat %0d busy %0d expected 0040/%0d/5", pSel, lat, bc, e.lat);
        end
        applyStimulus(2'd0, 1'b0, 8'd5, 8'd0);
        waitDone(lat, bc, ok);
        e = sbq.pop_front();
        vectors++;
        if (!ok || pSel !== 16'h0000 || bc !== 1 || lat !== 2) begin
            miscompares++; $display("[TB] FAIL b_zero: p %h lat %0d busy %0d expected 0000/2/1", pSel, lat, bc);
        end
    endtask

    task automatic test_signed_disabled();
        exp_t e; int lat, bc; bit ok;
        applyStimulus(2'd2, 1'b1, 8'hFF, 8'hFF);
        waitDone(lat, bc, ok);
        e = sbq.pop_front();
        vectors++;
        if (!ok || pSel !== 16'hFE01 || pSel !== e.p) begin
            miscompares++; $display("[TB] FAIL signed_disabled p: got %h expected fe01", pSel);
        end
        vectors++;
        if (bc !== 9 || lat !== e.lat) begin
            miscompares++; $display("[TB] FAIL signed_disabled timing: busy %0d lat %0d expected 9/%0d", bc, lat, e.lat);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e1, e2; int lat, bc; bit ok;
        @(negedge clk);
        selR = 2'd0; smIn = 1'b0; aIn = 8'd13; bIn = 8'd11; go = 1'b1;
        sbq.push_back(model(2'd0, 1'b0, 8'd13, 8'd11));
        @(negedge clk);
        aIn = 8'd9; bIn = 8'd6;
        sbq.push_back(model(2'd0, 1'b0, 8'd9, 8'd6));
        waitDone(lat, bc, ok);
        e1 = sbq.pop_front();
        vectors++;
        if (!ok || pSel !== e1.p || lat !== e1.lat) begin
            miscompares++; $display("[TB] FAIL b2b first: p %h lat %0d expected %h/%0d", pSel, lat, e1.p, e1.lat);
        end
        @(negedge clk);
        waitDone(lat, bc, ok);
        go = 1'b0;
        e2 = sbq.pop_front();
        vectors++;
        if (!ok || pSel !== e2.p || lat !== e2.lat + 1) begin
            miscompares++; $display("[TB] FAIL b2b second: p %h lat %0d expected %h/%0d", pSel, lat, e2.p, e2.lat + 1);
        end
    endtask

    task automatic test_go_while_busy();
        exp_t e; int lat, bc, extra; bit ok;
        applyStimulus(2'd1, 1'b0, 8'd200, 8'd201);
        aIn = 8'd3; bIn = 8'd3; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        waitDone(lat, bc, ok);
        e = sbq.pop_front();
        vectors++;
        if (!ok || pSel !== e.p || lat !== e.lat - 1) begin
            miscompares++; $display("[TB] FAIL go_busy: p %h lat %0d expected %h/%0d", pSel, lat, e.p, e.lat - 1);
        end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done8 || busy8) extra++;
        end
        vectors++;
        if (extra !== 0 || p8 !== e.p) begin
            miscompares++; $display("[TB] FAIL go_busy idle: activity %0d p %h expected 0/%h", extra, p8, e.p);
        end
    endtask

    task automatic test_reset_mid_op();
        exp_t e; int lat, bc; bit ok;
        applyStimulus(2'd1, 1'b0, 8'hFF, 8'hFF);
        @(negedge clk);
        vectors++;
        if (busy8 !== 1'b1) begin
            miscompares++; $display("[TB] FAIL abort busy_before: got %b expected 1", busy8);
        end
        #2 clr = 1'b0;
        #1;
        vectors++;
        if ({busy8, done8, p8} !== 18'd0) begin
            miscompares++; $display("[TB] FAIL abort async: got %h expected 0", {busy8, done8, p8});
        end
        void'(sbq.pop_front());
        @(negedge clk);
        clr = 1'b1;
        applyStimulus(2'd1, 1'b1, 8'hFD, 8'd7);
        waitDone(lat, bc, ok);
        e = sbq.pop_front();
        vectors++;
        if (!ok || pSel !== 16'hFFEB || lat !== e.lat) begin
            miscompares++; $display("[TB] FAIL after_abort: p %h lat %0d expected ffeb/%0d", pSel, lat, e.lat);
        end
    endtask

    task automatic test_random();
        exp_t e; int lat, bc; bit ok;
        for (int n = 0; n < 1000; n++) begin
            applyStimulus(2'd1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            waitDone(lat, bc, ok);
            e = sbq.pop_front();
            vectors++;
            if (!ok || pSel !== e.p) begin
                miscompares++; $display("[TB] FAIL random p #%0d: got %h expected %h", n, pSel, e.p);
            end
            vectors++;
            if (lat !== e.lat || bc !== e.busyCyc) begin
                miscompares++; $display("[TB] FAIL random timing #%0d: lat %0d busy %0d expected %0d/%0d", n, lat, bc, e.lat, e.busyCyc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_w4();
        test_signed_w4();
        test_signed_disabled();
        test_back_to_back();
        test_go_while_busy();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
